// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - ld/sd sequencer between execute, main memory and writeback
// Forms base+sext(offset), rejects misaligned/out-of-range accesses, one op in flight.
module load_store_unit #(
  parameter int MEM_DEPTH = 32,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [63:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_err
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_LOAD, S_WAIT, S_RESP} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mem_addr_q, mem_addr_d;
  logic [63:0]      mem_wdata_q, mem_wdata_d;
  logic [63:0]      wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_we_q, wb_we_d;
  logic             wb_err_q, wb_err_d;

  logic [63:0] ea;
  logic [60:0] word_idx;
  logic        acc_err;
  logic        accept;

  assign ea       = req_base + {{52{req_offset[11]}}, req_offset};
  assign word_idx = ea[63:3];
  // Out-of-range must be caught here: the memory itself silently wraps.
  assign acc_err  = (ea[2:0] != 3'b000) || (word_idx >= 61'(MEM_DEPTH));
  assign accept   = req_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_err)           state_d = S_RESP;
          else if (req_is_store) state_d = S_STORE;
          else                   state_d = S_LOAD;
        end
      end
      S_STORE: state_d = S_RESP;
      S_LOAD:  state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (state_q == S_IDLE);
    mem_write = (state_q == S_STORE);
    mem_read  = (state_q == S_LOAD);
    wb_valid  = (state_q == S_RESP);
  end

  always_comb begin
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = wb_we_q;
    wb_err_d    = wb_err_q;
    if (accept) begin
      wb_rd_d   = req_rd;
      wb_err_d  = acc_err;
      wb_we_d   = !req_is_store && !acc_err && (req_rd != 5'd0);
      wb_data_d = '0;
      if (!acc_err) begin
        mem_addr_d = {3'b000, word_idx};
        if (req_is_store) mem_wdata_d = req_wdata;
      end
    end
    if (state_q == S_LOAD) cnt_d = CNT_W'(READ_LAT - 1);
    if (state_q == S_WAIT) begin
      if (cnt_q == '0) wb_data_d = mem_rdata;
      else             cnt_d     = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_we     = wb_we_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - bench for load_store_unit with attached memory and reference model
module tb_load_store_unit;

  localparam int READ_LAT = 1;
  localparam int DEPTH    = 32;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [63:0] req_base;
  logic [11:0] req_offset;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_err;

  int n_checks;
  int n_errors;

  logic [63:0] tb_mem  [DEPTH];
  logic [63:0] ref_mem [DEPTH];

  load_store_unit #(.MEM_DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory with registered one-cycle read; reloaded from the reference image while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= ref_mem[i];
      mem_rdata <= '0;
    end else begin
      if (mem_write) tb_mem[mem_addr[4:0]] <= mem_wdata;
      if (mem_read)  mem_rdata <= tb_mem[mem_addr[4:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge after the handshake.
  task automatic run_op(input bit st, input logic [63:0] base, input logic [11:0] off,
                        input logic [63:0] wd, input logic [4:0] rd, input int stall);
    logic [63:0] ea;
    logic [60:0] w;
    bit          err;
    logic [63:0] exp_data;
    bit          exp_we;
    int          exp_lat, lat, nrd, nwr, nboth;
    ea       = base + {{52{off[11]}}, off};
    w        = ea[63:3];
    err      = (ea[2:0] != 3'd0) || (w >= 61'(DEPTH));
    exp_we   = !st && !err && (rd != 5'd0);
    exp_data = (st || err) ? 64'd0 : ref_mem[w[4:0]];
    if (st && !err) ref_mem[w[4:0]] = wd;
    exp_lat  = err ? 1 : (st ? 2 : 2 + READ_LAT);

    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_is_store = st; req_base = base;
    req_offset = off; req_wdata = wd; req_rd = rd;
    lat = 0; nrd = 0; nwr = 0; nboth = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (c == 0) begin
        // Scramble request fields after accept; the unit must not resample them.
        req_valid = 1'b0; req_is_store = ~st; req_base = {$urandom, $urandom};
        req_offset = 12'($urandom); req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);
      end
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      if (mem_read && mem_write) nboth++;
      if (mem_read || mem_write) check("mem_addr", mem_addr, {3'b000, w});
      if (mem_write) check("mem_wdata", mem_wdata, wd);
      if (wb_valid) break;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("read_strobes", 64'(nrd), (!st && !err) ? 64'd1 : 64'd0);
    check("write_strobes", 64'(nwr), (st && !err) ? 64'd1 : 64'd0);
    check("both_strobes", 64'(nboth), 64'd0);
    check("wb_err", {63'd0, wb_err}, {63'd0, err});
    check("wb_we", {63'd0, wb_we}, {63'd0, exp_we});
    check("wb_rd", {59'd0, wb_rd}, {59'd0, rd});
    check("wb_data", wb_data, exp_data);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, wb_valid}, 64'd1);
      check("stall_data", wb_data, exp_data);
      check("stall_req_ready", {63'd0, req_ready}, 64'd0);
      check("stall_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    check("post_hs_valid", {63'd0, wb_valid}, 64'd0);
    check("post_hs_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    bit          st;
    int          kind, w;
    logic [11:0] off;
    logic [63:0] base;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_base = '0;
    req_offset = '0; req_wdata = '0; req_rd = '0; wb_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = {$urandom, $urandom};
    ref_mem[3] = 64'hDEAD;
    repeat (3) @(negedge clk);
    check("rst_outputs", {mem_read, mem_write, wb_valid, req_ready, wb_we, wb_err}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 64'd16, 12'd8, 64'd0, 5'd7, 0);
    run_op(1'b1, 64'd0, 12'd40, 64'h1234, 5'd3, 0);
    run_op(1'b0, 64'd0, 12'd40, 64'd0, 5'd9, 0);
    run_op(1'b0, 64'd8, 12'hFF8, 64'd0, 5'd1, 0);
    run_op(1'b0, 64'd0, 12'hFF8, 64'd0, 5'd2, 0);
    run_op(1'b0, 64'd4, 12'd0, 64'd0, 5'd4, 0);
    run_op(1'b0, 64'd256, 12'd0, 64'd0, 5'd5, 0);
    run_op(1'b1, 64'd256, 12'd0, 64'hBAD, 5'd5, 0);
    run_op(1'b0, 64'd248, 12'd0, 64'd0, 5'd6, 0);
    run_op(1'b0, 64'd16, 12'd8, 64'd0, 5'd0, 0);
    run_op(1'b0, 64'd16, 12'd8, 64'd0, 5'd8, 4);

    for (int i = 0; i < 60; i++) begin
      st   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, DEPTH - 1);
      off  = 12'($urandom) & 12'hFF8;
      base = 64'(w * 8) - {{52{off[11]}}, off};
      if (kind == 7) base = base + 64'($urandom_range(1, 7));
      if (kind >= 8) base = {$urandom, $urandom};
      run_op(st, base, off, {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 3));
    end

    // Reset while the load is waiting on memory.
    req_valid = 1'b1; req_is_store = 1'b0; req_base = 64'd16; req_offset = 12'd8; req_rd = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_read_strobe", {63'd0, mem_read}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {mem_read, mem_write, wb_valid, req_ready, wb_we, wb_err}, 64'd0);
    check("abort_wb_data", wb_data, 64'd0);
    check("abort_wb_rd", {59'd0, wb_rd}, 64'd0);
    check("abort_mem_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_req_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_valid", {63'd0, wb_valid}, 64'd0);
    end
    run_op(1'b0, 64'd0, 12'd40, 64'd0, 5'd11, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
